// File: rtl/dsp_mac_seq_if.sv
// Stream, slice and result signals of the dsp_mac_seq sequencer.
// slave is the sequencer view; master is the source/slice/sink view.
interface dsp_mac_seq_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             sub;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      a_in;
    logic [17:0]      b_in;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      result;

    modport slave (
        input  start, len, sub,
        input  in_valid, a_in, b_in,
        input  dsp_p, res_ready,
        output busy, in_ready,
        output dsp_a, dsp_b, dsp_opmode,
        output res_valid, result
    );

    modport master (
        output start, len, sub,
        output in_valid, a_in, b_in,
        output dsp_p, res_ready,
        input  busy, in_ready,
        input  dsp_a, dsp_b, dsp_opmode,
        input  res_valid, result
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// MAC sequencer feeding a registered dsp slice (A1/B1/M/P/OPMODE regs).
// Optional DSP_MAC_SUB_EN: honour sub and issue subtract opcodes.
module dsp_mac_seq #(
    parameter int LEN_W = 8,
    parameter int LAT   = 3
) (
    input logic          CLK,
    input logic          RST,
    dsp_mac_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic vld;
        logic first;
    } tag_t;

    localparam int DW = $clog2(LAT + 2);
    localparam logic [DW-1:0] DRAIN_LD = DW'(LAT + 1);

    localparam logic [7:0] OP_HOLD  = 8'h08;
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_FSUB  = 8'h81;
    localparam logic [7:0] OP_SUB   = 8'h89;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [DW-1:0]    dcnt_q;
    logic             sub_q;
    logic             sub_sel;
    logic [17:0]      a_q;
    logic [17:0]      b_q;
    logic [47:0]      result_q;
    tag_t [LAT-2:0]   tag_q;
    tag_t             tap;
    logic [7:0]       opmode;

    logic busy;
    logic in_ready;
    logic res_valid;
    logic accept;
    logic last_beat;
    logic launch;
    logic drain_end;

`ifdef DSP_MAC_SUB_EN
    assign sub_sel = bus.sub;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign sub_sel    = 1'b0;
`endif

    assign accept    = in_ready & bus.in_valid;
    assign last_beat = (cnt_q == len_q - LEN_W'(1));
    assign launch    = (state == IDLE) & bus.start;
    assign drain_end = (state == DRAIN) & (dcnt_q == DW'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FEED;
                    end
                end
            end
            FEED: begin
                if (accept && last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b1;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (state)
            IDLE:    busy      = 1'b0;
            FEED:    in_ready  = 1'b1;
            DRAIN:   busy      = 1'b1;
            DONE:    res_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q <= '0;
            sub_q <= 1'b0;
            cnt_q <= '0;
        end else if (launch) begin
            len_q <= bus.len;
            sub_q <= sub_sel;
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    // Drain covers LAT edges of slice latency plus the result capture edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcnt_q <= '0;
        end else if (accept && last_beat) begin
            dcnt_q <= DRAIN_LD;
        end else if (state == DRAIN) begin
            dcnt_q <= dcnt_q - DW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q <= '0;
        end else if (launch && bus.len == '0) begin
            result_q <= '0;
        end else if (drain_end) begin
            result_q <= bus.dsp_p;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= bus.a_in;
            b_q <= bus.b_in;
        end else begin
            a_q <= '0;
            b_q <= '0;
        end
    end

    // Tag i describes the beat presented on dsp_a/dsp_b i cycles ago.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{vld: accept, first: accept && cnt_q == '0};
            for (int i = 1; i < LAT - 1; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tap = tag_q[LAT-2];

    always_comb begin
        opmode = OP_HOLD;
        unique case (1'b1)
            !tap.vld: begin
                opmode = OP_HOLD;
            end
            tap.vld && tap.first: begin
                opmode = sub_q ? OP_FSUB : OP_FIRST;
            end
            tap.vld && !tap.first: begin
                opmode = sub_q ? OP_SUB : OP_ACC;
            end
            default: opmode = OP_HOLD;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.in_ready   = in_ready;
    assign bus.res_valid  = res_valid;
    assign bus.result     = result_q;
    assign bus.dsp_a      = a_q;
    assign bus.dsp_b      = b_q;
    assign bus.dsp_opmode = opmode;
endmodule
